// File: rtl/axi_sram_slave.sv
// AXI4-subset memory responder: word-addressed array behind independent
// read and write channel state machines, INCR bursts with index wrap.
//
// state  | meaning
// R_IDLE | waiting for a read address, arready high
// R_WAIT | counting down the programmed read delay
// R_DATA | presenting read beats until the last one is accepted
// W_IDLE | waiting for a write address, awready high
// W_DATA | accepting write beats until wlast
// W_RESP | holding the write response until bready
module axi_sram_slave #(
    parameter int MEM_AW   = 10,
    parameter int RD_DELAY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    logic [31:0]       mem [0:(1<<MEM_AW)-1];

    rd_state_t         rd_state;
    logic [MEM_AW-1:0] rd_idx;
    logic [MEM_AW-1:0] rd_idx_nxt;
    logic [7:0]        rd_len;
    logic [7:0]        rd_cnt;
    logic [3:0]        rd_dly;

    wr_state_t         wr_state;
    logic [MEM_AW-1:0] wr_idx;
    logic [7:0]        wr_len;
    logic [7:0]        wr_cnt;
    logic              wr_over;

    // Address bits outside the word index and the size field are ignored.
    logic              unused;
    assign unused = ^{awsize, araddr[31:MEM_AW+2], araddr[1:0],
                      awaddr[31:MEM_AW+2], awaddr[1:0]};

    assign rresp      = 2'b00;
    assign rd_idx_nxt = rd_idx + 1'b1;

    // Read channel: accept address, optional delay, then stream beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rdata    <= '0;
            rd_idx   <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            rd_dly   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arvalid) begin
                        arready  <= 1'b0;
                        rd_idx   <= araddr[MEM_AW+1:2];
                        rd_len   <= arlen;
                        rd_cnt   <= '0;
                        rd_dly   <= 4'(RD_DELAY - 1);
                        rd_state <= (RD_DELAY > 0) ? R_WAIT : R_DATA;
                    end
                end
                R_WAIT: begin
                    if (rd_dly == 4'd0) rd_state <= R_DATA;
                    else                rd_dly   <= rd_dly - 4'd1;
                end
                R_DATA: begin
                    // First cycle in R_DATA loads the first word.
                    if (!rvalid) begin
                        rvalid <= 1'b1;
                        rdata  <= mem[rd_idx];
                        rlast  <= (rd_cnt == rd_len);
                    end else if (rready) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            rd_state <= R_IDLE;
                        end else begin
                            rd_idx <= rd_idx_nxt;
                            rd_cnt <= rd_cnt + 8'd1;
                            rdata  <= mem[rd_idx_nxt];
                            rlast  <= (rd_cnt + 8'd1 == rd_len);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Write channel: accept address, take beats until wlast, then respond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state <= W_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            wr_idx   <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_over  <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (awvalid) begin
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        wr_idx   <= awaddr[MEM_AW+1:2];
                        wr_len   <= awlen;
                        wr_cnt   <= '0;
                        wr_over  <= 1'b0;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        wr_idx <= wr_idx + 1'b1;
                        wr_cnt <= wr_cnt + 8'd1;
                        // Sticky: a beat at the nominal last slot without
                        // wlast means the burst ran long, even if wr_cnt wraps.
                        if (wr_cnt == wr_len) wr_over <= 1'b1;
                        if (wlast) begin
                            wready   <= 1'b0;
                            bvalid   <= 1'b1;
                            bresp    <= (wr_cnt == wr_len && !wr_over) ? 2'b00 : 2'b10;
                            wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        bresp    <= 2'b00;
                        awready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Byte-lane writes into the array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_state == W_DATA && wvalid) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
